// File: rtl/mux_hash_pkg.sv
// Shared types and select encodings for the mux-select hash round engine.
package mux_hash_pkg;

  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mh_state_t;

  localparam logic [SEL_W-1:0] SEL_HOLD = 2'b00;
  localparam logic [SEL_W-1:0] SEL_ROT  = 2'b01;
  localparam logic [SEL_W-1:0] SEL_XOR  = 2'b10;
  localparam logic [SEL_W-1:0] SEL_INV  = 2'b11;

endpackage

// File: rtl/mux_cell4.sv
// One-bit mux-select logic cell: select is (a1|b1, a0&b0), picks hold/rotated/keyed/inverted bit.
module mux_cell4
  import mux_hash_pkg::*;
(
  input  logic a1,
  input  logic b1,
  input  logic a0,
  input  logic b0,
  input  logic hold,
  input  logic rot,
  input  logic key,
  output logic y_c
);

  logic [SEL_W-1:0] sel_c;

  always_comb begin
    sel_c = {a1 | b1, a0 & b0};
    y_c   = hold;
    case (sel_c)
      SEL_HOLD: y_c = hold;
      SEL_ROT:  y_c = rot;
      SEL_XOR:  y_c = hold ^ key;
      SEL_INV:  y_c = ~hold;
      default:  y_c = hold;
    endcase
  end

endmodule

// File: rtl/mux_hash_core.sv
// Iterative hash round engine: WIDTH mux cells update the state for ROUNDS cycles per start.
// Optional MUX_HASH_CHAIN_EN adds a chain input that reuses the previous digest as the seed.
module mux_hash_core
  import mux_hash_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned ROT    = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
`ifdef MUX_HASH_CHAIN_EN
  input  logic             chain,
`endif
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] key,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] digest
);

  localparam int unsigned CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUNDS - 1);
  localparam int unsigned ROT_M = ROT % WIDTH;

  mh_state_t        st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d, a0_q, a0_d, b0_q, b0_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] rot_c;
  logic [WIDTH-1:0] mix_c;

  assign rot_c = (state_q << ROT_M) | (state_q >> (WIDTH - ROT_M));

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    mux_cell4 u_cell (
      .a1   (a1_q[i]),
      .b1   (b1_q[i]),
      .a0   (a0_q[i]),
      .b0   (b0_q[i]),
      .hold (state_q[i]),
      .rot  (rot_c[i]),
      .key  (key_q[i]),
      .y_c  (mix_c[i])
    );
  end

  // Next-state, counter and datapath loads; operands rotate after every round.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    a0_d    = a0_q;
    b0_d    = b0_q;
    key_d   = key_q;
    case (st_q)
      IDLE: begin
        if (start) begin
          st_d  = RUN;
          cnt_d = '0;
`ifdef MUX_HASH_CHAIN_EN
          state_d = chain ? state_q : seed;
`else
          state_d = seed;
`endif
          a1_d  = a1;
          b1_d  = b1;
          a0_d  = a0;
          b0_d  = b0;
          key_d = key;
        end
      end
      RUN: begin
        state_d = mix_c;
        a1_d    = {a1_q[WIDTH-2:0], a1_q[WIDTH-1]};
        b1_d    = {b1_q[WIDTH-2:0], b1_q[WIDTH-1]};
        a0_d    = {a0_q[WIDTH-2:0], a0_q[WIDTH-1]};
        b0_d    = {b0_q[WIDTH-2:0], b0_q[WIDTH-1]};
        // Hold the counter on the last round so it never wraps inside a run.
        if (cnt_q == CNT_LAST) begin
          st_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
    busy_d = (st_d == RUN);
    done_d = (st_d == DONE);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      a0_q    <= '0;
      b0_q    <= '0;
      key_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      a0_q    <= a0_d;
      b0_q    <= b0_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign digest = state_q;

endmodule

// File: tb/tb_mux_hash_core.sv
// Self-checking bench: three engines (16/5/3 rounds) share stimulus and are compared to a word-level model.
module tb_mux_hash_core;

  localparam int unsigned W = 8;
  localparam int unsigned NI = 3;

  logic         clk;
  logic         clr_n;
  logic         start;
`ifdef MUX_HASH_CHAIN_EN
  logic         chain;
`endif
  logic [W-1:0] seed, a1, b1, a0, b0, key;
  logic         busy_w [NI];
  logic         done_w [NI];
  logic [W-1:0] dig_w  [NI];

  int checks;
  int errors;

  mux_hash_core #(.WIDTH(W), .ROUNDS(16), .ROT(1)) u_r16 (
    .clk(clk), .clr_n(clr_n), .start(start),
`ifdef MUX_HASH_CHAIN_EN
    .chain(chain),
`endif
    .seed(seed), .a1(a1), .b1(b1), .a0(a0), .b0(b0), .key(key),
    .busy(busy_w[0]), .done(done_w[0]), .digest(dig_w[0])
  );

  mux_hash_core #(.WIDTH(W), .ROUNDS(5), .ROT(1)) u_r5 (
    .clk(clk), .clr_n(clr_n), .start(start),
`ifdef MUX_HASH_CHAIN_EN
    .chain(chain),
`endif
    .seed(seed), .a1(a1), .b1(b1), .a0(a0), .b0(b0), .key(key),
    .busy(busy_w[1]), .done(done_w[1]), .digest(dig_w[1])
  );

  mux_hash_core #(.WIDTH(W), .ROUNDS(3), .ROT(1)) u_r3 (
    .clk(clk), .clr_n(clr_n), .start(start),
`ifdef MUX_HASH_CHAIN_EN
    .chain(chain),
`endif
    .seed(seed), .a1(a1), .b1(b1), .a0(a0), .b0(b0), .key(key),
    .busy(busy_w[2]), .done(done_w[2]), .digest(dig_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rounds_of(input int i);
    case (i)
      0:       return 16;
      1:       return 5;
      default: return 3;
    endcase
  endfunction

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int r);
    int rr;
    rr = r % W;
    if (rr == 0) return x;
    return (x << rr) | (x >> (W - rr));
  endfunction

  // One round on whole words: each bit picks its source from the (s1,s0) pair.
  function automatic logic [W-1:0] round_fn(input logic [W-1:0] st, input logic [W-1:0] p1,
                                            input logic [W-1:0] q1, input logic [W-1:0] p0,
                                            input logic [W-1:0] q0, input logic [W-1:0] k);
    logic [W-1:0] s1, s0;
    s1 = p1 | q1;
    s0 = p0 & q0;
    return (~s1 & ~s0 & st) | (~s1 & s0 & rotl(st, 1)) |
           (s1 & ~s0 & (st ^ k)) | (s1 & s0 & ~st);
  endfunction

  // Reference model: phase 0 idle, 1 running, 2 done pulse.
  int           m_phase [NI];
  int           m_cnt   [NI];
  logic [W-1:0] m_st [NI], m_a1 [NI], m_b1 [NI], m_a0 [NI], m_b0 [NI], m_k [NI];

  always @(posedge clk or negedge clr_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!clr_n) begin
        m_phase[i] <= 0;
        m_cnt[i]   <= 0;
        m_st[i]    <= '0;
        m_a1[i]    <= '0;
        m_b1[i]    <= '0;
        m_a0[i]    <= '0;
        m_b0[i]    <= '0;
        m_k[i]     <= '0;
      end else if (m_phase[i] == 0) begin
        if (start) begin
          m_phase[i] <= 1;
          m_cnt[i]   <= 0;
`ifdef MUX_HASH_CHAIN_EN
          m_st[i]    <= chain ? m_st[i] : seed;
`else
          m_st[i]    <= seed;
`endif
          m_a1[i] <= a1;
          m_b1[i] <= b1;
          m_a0[i] <= a0;
          m_b0[i] <= b0;
          m_k[i]  <= key;
        end
      end else if (m_phase[i] == 1) begin
        m_st[i]  <= round_fn(m_st[i], m_a1[i], m_b1[i], m_a0[i], m_b0[i], m_k[i]);
        m_a1[i]  <= rotl(m_a1[i], 1);
        m_b1[i]  <= rotl(m_b1[i], 1);
        m_a0[i]  <= rotl(m_a0[i], 1);
        m_b0[i]  <= rotl(m_b0[i], 1);
        m_cnt[i] <= m_cnt[i] + 1;
        if (m_cnt[i] + 1 == rounds_of(i)) m_phase[i] <= 2;
      end else begin
        m_phase[i] <= 0;
      end
    end
  end

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s inst%0d @%0t: got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk("busy", i, 32'(busy_w[i]), 32'(m_phase[i] == 1));
      chk("done", i, 32'(done_w[i]), 32'(m_phase[i] == 2));
      chk("digest", i, 32'(dig_w[i]), 32'(m_st[i]));
    end
  end

  // Launch one start and watch 40 cycles; checks latency, busy length and single done pulse.
  task automatic fire(input logic [W-1:0] sd, input logic [W-1:0] p1, input logic [W-1:0] q1,
                      input logic [W-1:0] p0, input logic [W-1:0] q0, input logic [W-1:0] kv,
                      input bit extra);
    int lat [NI];
    int bc  [NI];
    int dc  [NI];
    @(negedge clk);
    seed = sd; a1 = p1; b1 = q1; a0 = p0; b0 = q0; key = kv;
    start = 1'b1;
    for (int i = 0; i < NI; i++) begin
      lat[i] = -1; bc[i] = 0; dc[i] = 0;
    end
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      start = extra && (t % 3 == 0) && (t < 15);
      for (int i = 0; i < NI; i++) begin
        if (busy_w[i]) bc[i]++;
        if (done_w[i]) begin
          dc[i]++;
          if (lat[i] < 0) lat[i] = t;
        end
      end
    end
    if (!extra) begin
      for (int i = 0; i < NI; i++) begin
        chk("latency", i, 32'(lat[i]), 32'(rounds_of(i) + 1));
        chk("busy_len", i, 32'(bc[i]), 32'(rounds_of(i)));
        chk("done_cnt", i, 32'(dc[i]), 32'd1);
      end
    end else begin
      chk("done_cnt_ignore", 0, 32'(dc[0]), 32'd1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr_n = 1'b0;
    start = 1'b0;
`ifdef MUX_HASH_CHAIN_EN
    chain = 1'b0;
`endif
    seed = '0; a1 = '0; b1 = '0; a0 = '0; b0 = '0; key = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 0, 32'(busy_w[0]), 32'd0);
    chk("rst_done", 0, 32'(done_w[0]), 32'd0);
    chk("rst_digest", 0, 32'(dig_w[0]), 32'd0);
    #2 clr_n = 1'b1;

    // Hold: every cell selects its own bit.
    fire(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("hold", 0, 32'(dig_w[0]), 32'h0A5);
    // Invert: odd round count flips, even count restores.
    fire(8'hA5, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0);
    chk("invert_r5", 1, 32'(dig_w[1]), 32'h05A);
    chk("invert_r16", 0, 32'(dig_w[0]), 32'h0A5);
    // Rotate: three rotl-by-1 of 0x81.
    fire(8'h81, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0);
    chk("rotate_r3", 2, 32'(dig_w[2]), 32'h00C);
    chk("rotate_r5", 1, 32'(dig_w[1]), 32'h030);
    // Xor with all-ones key.
    fire(8'h3C, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0);
    chk("xor_r5", 1, 32'(dig_w[1]), 32'h0C3);
    chk("xor_r16", 0, 32'(dig_w[0]), 32'h03C);
    // Extra start pulses while the 16-round engine runs must not retrigger it.
    fire(8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

    // Abort mid-run with an asynchronous reset.
    @(negedge clk);
    seed = 8'h77; a1 = 8'h0F; b1 = 8'h30; a0 = 8'hF0; b0 = 8'h3C; key = 8'h99;
    start = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort_busy_pre", 0, 32'(busy_w[0]), 32'd1);
    #2 clr_n = 1'b0;
    #1;
    chk("abort_busy", 0, 32'(busy_w[0]), 32'd0);
    chk("abort_done", 0, 32'(done_w[0]), 32'd0);
    chk("abort_digest", 0, 32'(dig_w[0]), 32'd0);
    @(negedge clk);
    #2 clr_n = 1'b1;
    fire(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("post_abort", 0, 32'(dig_w[0]), 32'h0A5);

`ifdef MUX_HASH_CHAIN_EN
    fire(8'hA5, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0);
    chk("chain_pre", 1, 32'(dig_w[1]), 32'h05A);
    chain = 1'b1;
    fire(8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0);
    chain = 1'b0;
    chk("chain", 1, 32'(dig_w[1]), 32'h0A5);
`endif

    // Random traffic, model compared every cycle.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      seed  = W'($urandom);
      a1    = ($urandom_range(0, 4) == 0) ? 8'hFF : W'($urandom);
      b1    = ($urandom_range(0, 4) == 0) ? 8'h00 : W'($urandom);
      a0    = W'($urandom);
      b0    = ($urandom_range(0, 4) == 0) ? 8'hFF : W'($urandom);
      key   = W'($urandom);
`ifdef MUX_HASH_CHAIN_EN
      chain = ($urandom_range(0, 2) == 0);
`endif
    end
    start = 1'b0;
    repeat (25) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
